// File: rtl/btb_upd_ctrl_if.sv
// btb_upd_ctrl_if
// Bundles every handshake and BTB-side signal of btb_upd_ctrl.
//   slave  : view used by btb_upd_ctrl itself
//   master : view used by the producer / BTB side (decode, retire, bench)
// Groups:
//   sp_*      speculative-write request from decode (valid/ready + payload)
//   rt_*      retire direction-update request (valid/ready + payload)
//   inv_*     invalidate-all request and its busy/done status
//   btb_sp_*  BTB speculative write port (plus btb_ras_ctl_o)
//   btb_rt_*  BTB retire update port
//   btb_inv_* BTB set-invalidate port, index = PC[9:2] set number
interface btb_upd_ctrl_if;
    logic        sp_valid_i;
    logic        sp_ready_o;
    logic [2:0]  sp_brpos_i;
    logic [1:0]  sp_brtyp_i;
    logic [63:0] sp_brpc_i;
    logic [63:0] sp_brtar_i;
    logic [1:0]  sp_rasctl_i;

    logic        rt_valid_i;
    logic        rt_ready_o;
    logic        rt_brdir_i;
    logic [63:0] rt_brpc_i;

    logic        inv_req_i;
    logic        inv_busy_o;
    logic        inv_done_o;

    logic        btb_sp_we_o;
    logic [2:0]  btb_sp_brpos_o;
    logic [1:0]  btb_sp_brtyp_o;
    logic [63:0] btb_sp_brpc_o;
    logic [63:0] btb_sp_brtar_o;
    logic [1:0]  btb_ras_ctl_o;

    logic        btb_rt_we_o;
    logic        btb_rt_brdir_o;
    logic [63:0] btb_rt_brpc_o;

    logic        btb_inv_we_o;
    logic [7:0]  btb_inv_idx_o;

    modport slave (
        input  sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
        input  rt_valid_i, rt_brdir_i, rt_brpc_i, inv_req_i,
        output sp_ready_o, rt_ready_o, inv_busy_o, inv_done_o,
        output btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o, btb_sp_brtar_o,
        output btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
        output btb_inv_we_o, btb_inv_idx_o
    );

    modport master (
        output sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
        output rt_valid_i, rt_brdir_i, rt_brpc_i, inv_req_i,
        input  sp_ready_o, rt_ready_o, inv_busy_o, inv_done_o,
        input  btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o, btb_sp_brtar_o,
        input  btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
        input  btb_inv_we_o, btb_inv_idx_o
    );
endinterface

// File: rtl/btb_upd_ctrl.sv
// btb_upd_ctrl
// Serialises speculative BTB writes (SP_QDEPTH-deep FIFO, tail coalescing),
// retire direction updates (1-entry holding register) and an invalidate-all
// walk onto three mutually exclusive, registered BTB write ports.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : btb_upd_ctrl_if.slave (sp/rt handshakes, inv control, BTB ports)
// Retire normally wins arbitration; after STARVE_LIM consecutive retire wins
// over a non-empty FIFO the FIFO head is forced through.
module btb_upd_ctrl #(
    parameter int SP_QDEPTH  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic           clock,
    input  logic           reset,
    btb_upd_ctrl_if.slave  bus
);
    localparam int PW = (SP_QDEPTH > 1) ? $clog2(SP_QDEPTH) : 1;
    localparam int CW = $clog2(SP_QDEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef struct packed {
        logic [2:0]  brpos;
        logic [1:0]  brtyp;
        logic [63:0] brpc;
        logic [63:0] brtar;
        logic [1:0]  rasctl;
    } sp_ent_t;

    typedef struct packed {
        logic        brdir;
        logic [63:0] brpc;
    } rt_ent_t;

    typedef enum logic [1:0] {ARB, DRAIN, INV, DONE} state_t;

    state_t        state;
    sp_ent_t       fifo [SP_QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [CW-1:0] count;
    rt_ent_t       rt_hold;
    logic          rt_vld;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    inv_idx;

    sp_ent_t sp_in;
    logic    arb_en, fifo_ne, fifo_full, force_sp, rt_issue, sp_issue;
    logic    coalesce_ok, sp_acc, sp_push, sp_merge, rt_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SP_QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sp_in     = '{brpos: bus.sp_brpos_i, brtyp: bus.sp_brtyp_i, brpc: bus.sp_brpc_i,
                      brtar: bus.sp_brtar_i, rasctl: bus.sp_rasctl_i};
        arb_en    = (state == ARB) || (state == DRAIN);
        fifo_ne   = (count != '0);
        fifo_full = (count == CW'(SP_QDEPTH));
        force_sp  = fifo_ne && (starve_cnt == SW'(STARVE_LIM));
        rt_issue  = arb_en && rt_vld && !force_sp;
        sp_issue  = arb_en && fifo_ne && !rt_issue;
        tail_ptr  = (wr_ptr == '0) ? PW'(SP_QDEPTH - 1) : wr_ptr - 1'b1;
        // Never merge into an entry that is leaving this very cycle, or the
        // new payload would be lost with the pop.
        coalesce_ok = fifo_ne && (fifo[tail_ptr].brpc == bus.sp_brpc_i)
                      && !(sp_issue && (count == CW'(1)));
        sp_acc    = bus.sp_valid_i && bus.sp_ready_o;
        sp_merge  = sp_acc && coalesce_ok;
        sp_push   = sp_acc && !coalesce_ok;
        rt_acc    = bus.rt_valid_i && bus.rt_ready_o;
    end

    assign bus.sp_ready_o = (state == ARB) && (!fifo_full || coalesce_ok);
    assign bus.rt_ready_o = (state == ARB) && (!rt_vld || rt_issue);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ARB;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            rt_vld             <= 1'b0;
            rt_hold            <= '0;
            starve_cnt         <= '0;
            inv_idx            <= '0;
            bus.inv_busy_o     <= 1'b0;
            bus.inv_done_o     <= 1'b0;
            bus.btb_sp_we_o    <= 1'b0;
            bus.btb_sp_brpos_o <= '0;
            bus.btb_sp_brtyp_o <= '0;
            bus.btb_sp_brpc_o  <= '0;
            bus.btb_sp_brtar_o <= '0;
            bus.btb_ras_ctl_o  <= '0;
            bus.btb_rt_we_o    <= 1'b0;
            bus.btb_rt_brdir_o <= 1'b0;
            bus.btb_rt_brpc_o  <= '0;
            bus.btb_inv_we_o   <= 1'b0;
            bus.btb_inv_idx_o  <= '0;
        end else begin
            // speculative FIFO
            if (sp_push) begin
                fifo[wr_ptr] <= sp_in;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (sp_merge)
                fifo[tail_ptr] <= sp_in;
            if (sp_issue)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({sp_push, sp_issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // retire holding register
            if (rt_acc) begin
                rt_hold <= '{brdir: bus.rt_brdir_i, brpc: bus.rt_brpc_i};
                rt_vld  <= 1'b1;
            end else if (rt_issue) begin
                rt_vld  <= 1'b0;
            end

            if (sp_issue || !fifo_ne)
                starve_cnt <= '0;
            else if (rt_issue && (starve_cnt != SW'(STARVE_LIM)))
                starve_cnt <= starve_cnt + 1'b1;

            // BTB ports: strobes every cycle, payloads only on issue (hold otherwise)
            bus.btb_sp_we_o <= sp_issue;
            if (sp_issue) begin
                bus.btb_sp_brpos_o <= fifo[rd_ptr].brpos;
                bus.btb_sp_brtyp_o <= fifo[rd_ptr].brtyp;
                bus.btb_sp_brpc_o  <= fifo[rd_ptr].brpc;
                bus.btb_sp_brtar_o <= fifo[rd_ptr].brtar;
                bus.btb_ras_ctl_o  <= fifo[rd_ptr].rasctl;
            end
            bus.btb_rt_we_o <= rt_issue;
            if (rt_issue) begin
                bus.btb_rt_brdir_o <= rt_hold.brdir;
                bus.btb_rt_brpc_o  <= rt_hold.brpc;
            end

            // invalidate sequencing; busy/done/inv_we are loaded with the
            // value of the state being entered so they line up with it
            bus.btb_inv_we_o <= 1'b0;
            bus.inv_done_o   <= 1'b0;
            case (state)
                ARB: if (bus.inv_req_i) begin
                    state          <= DRAIN;
                    bus.inv_busy_o <= 1'b1;
                end
                DRAIN: if (!fifo_ne && !rt_vld) begin
                    state             <= INV;
                    bus.btb_inv_we_o  <= 1'b1;
                    bus.btb_inv_idx_o <= inv_idx;
                    inv_idx           <= inv_idx + 1'b1;
                end
                INV: begin
                    // inv_idx wraps to 0 once index 255 has been presented
                    if (inv_idx == 8'd0) begin
                        state          <= DONE;
                        bus.inv_done_o <= 1'b1;
                    end else begin
                        bus.btb_inv_we_o  <= 1'b1;
                        bus.btb_inv_idx_o <= inv_idx;
                        inv_idx           <= inv_idx + 1'b1;
                    end
                end
                default: begin
                    state          <= ARB;
                    bus.inv_busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btb_upd_ctrl.sv
module tb_btb_upd_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    btb_upd_ctrl_if bus();
    btb_upd_ctrl #(.SP_QDEPTH(2), .STARVE_LIM(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]  kind;   // 0 sp, 1 rt, 2 inv, 3 done
        logic [63:0] a;
        logic [63:0] b;
        logic [6:0]  m;
    } exp_t;

    exp_t q_sp[$];
    exp_t q_rt[$];
    exp_t q_inv[$];
    int   total = 0;
    int   bad = 0;
    int   rt_run = 0;
    int   sp_run_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexp(input string nm);
        total++;
        bad++;
        $display("FAIL %s unexpected output event t=%0t", nm, $time);
    endtask

    task automatic push_sp(input logic [63:0] pc, input logic [63:0] tar, input logic [6:0] m);
        exp_t e;
        e = '{kind: 2'd0, a: pc, b: tar, m: m};
        q_sp.push_back(e);
    endtask

    task automatic push_rt(input logic [63:0] pc, input logic dir);
        exp_t e;
        e = '{kind: 2'd1, a: pc, b: {63'd0, dir}, m: 7'd0};
        q_rt.push_back(e);
    endtask

    task automatic push_walk(input int n, input bit with_done);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{kind: 2'd2, a: 64'(i), b: 64'd0, m: 7'd0};
            q_inv.push_back(e);
        end
        if (with_done) begin
            e = '{kind: 2'd3, a: 64'd0, b: 64'd0, m: 7'd0};
            q_inv.push_back(e);
        end
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int c = 0;
        while ((q_sp.size() + q_rt.size() + q_inv.size()) != 0 && c < lim) begin
            @(negedge clock);
            c++;
        end
        chk(nm, 64'(q_sp.size() + q_rt.size() + q_inv.size()), 64'd0);
    endtask

    task automatic wait_done(input string nm, input int lim);
        int c = 0;
        while (!bus.inv_done_o && c < lim) begin
            @(negedge clock);
            c++;
        end
        chk(nm, 64'(bus.inv_done_o), 64'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({bus.btb_sp_we_o, bus.btb_rt_we_o, bus.btb_inv_we_o,
                                bus.inv_busy_o, bus.inv_done_o}), 64'd0);
        chk({nm, "_sppc"}, bus.btb_sp_brpc_o, 64'd0);
        chk({nm, "_sptar"}, bus.btb_sp_brtar_o, 64'd0);
        chk({nm, "_rtpc"}, bus.btb_rt_brpc_o, 64'd0);
        chk({nm, "_misc"}, 64'({bus.btb_sp_brpos_o, bus.btb_sp_brtyp_o, bus.btb_ras_ctl_o,
                                 bus.btb_rt_brdir_o, bus.btb_inv_idx_o}), 64'd0);
    endtask

    task automatic drive_sp_stream(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.sp_valid_i  = 1'b1;
            bus.sp_brpc_i   = 64'h100 + 64'(i) * 64'h10;
            bus.sp_brtar_i  = 64'h8000 + 64'(i) * 64'h8;
            bus.sp_brpos_i  = 3'(i);
            bus.sp_brtyp_i  = 2'(i);
            bus.sp_rasctl_i = 2'(i + 1);
            #1;
            w = 0;
            while (!bus.sp_ready_o && w < 50) begin
                @(negedge clock);
                #1;
                w++;
            end
            if (w >= 50) begin
                unexp("sp_stream_ready_timeout");
                break;
            end
            @(posedge clock);
        end
        @(negedge clock);
        bus.sp_valid_i = 1'b0;
    endtask

    task automatic drive_rt_stream(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.rt_valid_i = 1'b1;
            bus.rt_brpc_i  = 64'h900 + 64'(i) * 64'h4;
            bus.rt_brdir_i = i[0];
            #1;
            w = 0;
            while (!bus.rt_ready_o && w < 50) begin
                @(negedge clock);
                #1;
                w++;
            end
            if (w >= 50) begin
                unexp("rt_stream_ready_timeout");
                break;
            end
            @(posedge clock);
        end
        @(negedge clock);
        bus.rt_valid_i = 1'b0;
    endtask

    // monitor: pops the expected queue of whichever port fires
    initial begin
        exp_t e;
        int   nwe;
        forever begin
            @(negedge clock);
            nwe = int'(bus.btb_sp_we_o) + int'(bus.btb_rt_we_o) + int'(bus.btb_inv_we_o);
            if (nwe != 0) chk("we_exclusive", 64'(nwe), 64'd1);
            if (bus.btb_sp_we_o) begin
                if (q_sp.size() == 0) unexp("sp_issue");
                else begin
                    e = q_sp.pop_front();
                    chk("sp_pc", bus.btb_sp_brpc_o, e.a);
                    chk("sp_tar", bus.btb_sp_brtar_o, e.b);
                    chk("sp_misc", 64'({bus.btb_sp_brpos_o, bus.btb_sp_brtyp_o, bus.btb_ras_ctl_o}),
                        64'(e.m));
                end
                sp_run_log.push_back(rt_run);
                rt_run = 0;
            end
            if (bus.btb_rt_we_o) begin
                if (q_rt.size() == 0) unexp("rt_issue");
                else begin
                    e = q_rt.pop_front();
                    chk("rt_pc", bus.btb_rt_brpc_o, e.a);
                    chk("rt_dir", 64'(bus.btb_rt_brdir_o), e.b);
                end
                rt_run++;
            end
            if (bus.btb_inv_we_o || bus.inv_done_o) begin
                if (q_inv.size() == 0) unexp("inv_or_done");
                else begin
                    e = q_inv.pop_front();
                    chk("inv_kind", bus.btb_inv_we_o ? 64'd2 : 64'd3, 64'(e.kind));
                    if (bus.btb_inv_we_o) chk("inv_idx", 64'(bus.btb_inv_idx_o), e.a);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c, nbusy;
        reset = 1'b1;
        bus.sp_valid_i = 0; bus.sp_brpos_i = 0; bus.sp_brtyp_i = 0;
        bus.sp_brpc_i = 0; bus.sp_brtar_i = 0; bus.sp_rasctl_i = 0;
        bus.rt_valid_i = 0; bus.rt_brdir_i = 0; bus.rt_brpc_i = 0;
        bus.inv_req_i = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        #1;
        chk("reset_rdy", 64'({bus.sp_ready_o, bus.rt_ready_o}), 64'd3);

        // single speculative write: issues in the cycle after the second edge
        @(negedge clock);
        bus.sp_valid_i = 1; bus.sp_brpc_i = 64'h1000; bus.sp_brtar_i = 64'h2000;
        bus.sp_brpos_i = 3'd5; bus.sp_brtyp_i = 2'd2; bus.sp_rasctl_i = 2'd1;
        push_sp(64'h1000, 64'h2000, {3'd5, 2'd2, 2'd1});
        @(posedge clock);
        @(negedge clock);
        bus.sp_valid_i = 0;
        chk("t1_we_edge0", 64'(bus.btb_sp_we_o), 64'd0);
        @(negedge clock);
        chk("t1_we_edge1", 64'(bus.btb_sp_we_o), 64'd1);
        @(negedge clock);
        chk("t1_we_once", 64'(bus.btb_sp_we_o), 64'd0);
        chk("t1_hold_pc", bus.btb_sp_brpc_o, 64'h1000);
        chk("t1_rdy", 64'(bus.sp_ready_o), 64'd1);
        wait_drain("t1_drain", 20);

        // coalesce: a retire holds the port so the second write merges
        @(negedge clock);
        bus.sp_valid_i = 1; bus.sp_brpc_i = 64'h40; bus.sp_brtar_i = 64'h80;
        bus.sp_brpos_i = 3'd1; bus.sp_brtyp_i = 2'd1; bus.sp_rasctl_i = 2'd2;
        bus.rt_valid_i = 1; bus.rt_brpc_i = 64'h7000; bus.rt_brdir_i = 1;
        push_rt(64'h7000, 1'b1);
        push_sp(64'h40, 64'hC0, {3'd6, 2'd1, 2'd2});
        @(posedge clock);
        @(negedge clock);
        bus.rt_valid_i = 0;
        bus.sp_brtar_i = 64'hC0; bus.sp_brpos_i = 3'd6;
        #1;
        chk("t2_coal_rdy", 64'(bus.sp_ready_o), 64'd1);
        @(posedge clock);
        @(negedge clock);
        bus.sp_valid_i = 0;
        wait_drain("t2_drain", 20);
        repeat (4) @(negedge clock);

        // concurrent streams: starvation limit and full-FIFO backpressure
        base = sp_run_log.size();
        for (int i = 0; i < 10; i++) begin
            push_sp(64'h100 + 64'(i) * 64'h10, 64'h8000 + 64'(i) * 64'h8,
                    {3'(i), 2'(i), 2'(i + 1)});
            push_rt(64'h900 + 64'(i) * 64'h4, i[0]);
        end
        @(posedge clock);
        fork
            drive_sp_stream(10);
            drive_rt_stream(10);
            begin
                @(negedge clock);
                @(posedge clock);
                @(posedge clock);
                @(negedge clock);
                #2;
                chk("t3_full_rdy", 64'(bus.sp_ready_o), 64'd0);
            end
        join
        wait_drain("t3_drain", 100);
        if (sp_run_log.size() < base + 2) unexp("t3_sp_issue_count");
        else begin
            chk("t3_starve_a", 64'(sp_run_log[base]), 64'd4);
            chk("t3_starve_b", 64'(sp_run_log[base + 1]), 64'd4);
        end
        repeat (4) @(negedge clock);

        // invalidate with 2 FIFO entries and 1 held retire pending
        push_rt(64'h5000, 1'b1);
        push_rt(64'h5004, 1'b0);
        push_sp(64'h3000, 64'h3100, {3'd2, 2'd3, 2'd0});
        push_sp(64'h3040, 64'h3140, {3'd4, 2'd0, 2'd3});
        push_walk(256, 1'b1);
        @(negedge clock);
        bus.sp_valid_i = 1; bus.sp_brpc_i = 64'h3000; bus.sp_brtar_i = 64'h3100;
        bus.sp_brpos_i = 3'd2; bus.sp_brtyp_i = 2'd3; bus.sp_rasctl_i = 2'd0;
        bus.rt_valid_i = 1; bus.rt_brpc_i = 64'h5000; bus.rt_brdir_i = 1;
        @(posedge clock);
        @(negedge clock);
        bus.sp_brpc_i = 64'h3040; bus.sp_brtar_i = 64'h3140;
        bus.sp_brpos_i = 3'd4; bus.sp_brtyp_i = 2'd0; bus.sp_rasctl_i = 2'd3;
        bus.rt_brpc_i = 64'h5004; bus.rt_brdir_i = 0;
        @(posedge clock);
        @(negedge clock);
        bus.sp_valid_i = 0; bus.rt_valid_i = 0; bus.inv_req_i = 1;
        @(posedge clock);
        @(negedge clock);
        bus.inv_req_i = 0;
        chk("t4_busy_start", 64'(bus.inv_busy_o), 64'd1);
        #1;
        chk("t4_rdy_off", 64'({bus.sp_ready_o, bus.rt_ready_o}), 64'd0);
        c = 0;
        nbusy = 0;
        while (!bus.inv_done_o && c < 400) begin
            @(negedge clock);
            c++;
            bus.inv_req_i = (c == 100);   // must be ignored mid-walk
            if (!bus.inv_busy_o) nbusy++;
        end
        bus.inv_req_i = 0;
        chk("t4_done_cycle", 64'(c), 64'd259);
        chk("t4_busy_gap", 64'(nbusy), 64'd0);
        @(negedge clock);
        chk("t4_after", 64'({bus.inv_busy_o, bus.inv_done_o}), 64'd0);
        repeat (6) @(negedge clock);
        wait_drain("t4_drain", 10);

        // reset in the middle of a walk, then a fresh walk from index 0
        push_walk(101, 1'b0);
        @(negedge clock);
        bus.inv_req_i = 1;
        @(negedge clock);
        bus.inv_req_i = 0;
        c = 0;
        while (!(bus.btb_inv_we_o && bus.btb_inv_idx_o == 8'd100) && c < 300) begin
            @(negedge clock);
            c++;
        end
        chk("t5_reached_100", 64'(bus.btb_inv_idx_o), 64'd100);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("t5_reset");
        reset = 1'b0;
        chk("t5_walk_cut", 64'(q_inv.size()), 64'd0);
        repeat (3) @(negedge clock);
        push_walk(256, 1'b1);
        bus.inv_req_i = 1;
        @(negedge clock);
        bus.inv_req_i = 0;
        wait_done("t5_done", 400);
        wait_drain("t5_drain", 10);
        repeat (5) @(negedge clock);

        chk("end_queues", 64'(q_sp.size() + q_rt.size() + q_inv.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btb_upd_ctrl.md
BTB_UPD_CTRL -- requirements
Module: btb_upd_ctrl

Interface
REQ-001 Parameter SP_QDEPTH, default 2, depth of the speculative-write queue.
REQ-002 Parameter STARVE_LIM, default 4, consecutive retire wins before the speculative path is forced through.
REQ-003 Port clock  in  1  the single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports sp_valid_i in 1 / sp_ready_o out 1: speculative-write handshake from decode.
REQ-006 Ports sp_brpos_i in 3, sp_brtyp_i in 2, sp_brpc_i in 64, sp_brtar_i in 64, sp_rasctl_i in 2: speculative-write payload.
REQ-007 Ports rt_valid_i in 1 / rt_ready_o out 1: retire direction-update handshake.
REQ-008 Ports rt_brdir_i in 1, rt_brpc_i in 64: retire payload.
REQ-009 Ports inv_req_i in 1 (invalidate-all request), inv_busy_o out 1, inv_done_o out 1.
REQ-010 Ports btb_sp_we_o out 1, btb_sp_brpos_o out 3, btb_sp_brtyp_o out 2, btb_sp_brpc_o out 64, btb_sp_brtar_o out 64, btb_ras_ctl_o out 2: BTB speculative write port.
REQ-011 Ports btb_rt_we_o out 1, btb_rt_brdir_o out 1, btb_rt_brpc_o out 64: BTB retire update port.
REQ-012 Ports btb_inv_we_o out 1, btb_inv_idx_o out 8: BTB set-invalidate port, index = PC[9:2] set number.

Function
REQ-013 Storage SHALL be a SP_QDEPTH-entry FIFO for speculative writes and a 1-entry holding register for retire updates.
REQ-014 A request is accepted on a rising edge where valid and ready are both high.
REQ-015 sp_ready_o SHALL be high when state is ARB and the FIFO is not full, or when the incoming sp_brpc_i equals the FIFO tail brpc (coalesce case).
REQ-016 Coalesce: an accepted sp request whose brpc matches the valid tail entry SHALL overwrite that entry; occupancy is unchanged.
REQ-017 rt_ready_o SHALL be high when state is ARB and the holding register is empty or is being issued in the same cycle.
REQ-018 At most one of btb_sp_we_o, btb_rt_we_o, btb_inv_we_o SHALL be high in any cycle.
REQ-019 Arbitration each cycle: retire holding valid wins, except when starve_cnt == STARVE_LIM and the FIFO is non-empty, in which case the FIFO head wins.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIM) when retire wins while the FIFO is non-empty, and clear when an sp entry issues or the FIFO is empty.
REQ-021 The winner SHALL be driven on registered outputs: a request accepted at edge k issues at the earliest at edge k+1, with we high for exactly one cycle and the payload valid in that same cycle.
REQ-022 Payload outputs SHALL hold their last value when the corresponding we is low.
REQ-023 States: ARB, DRAIN, INV, DONE.
REQ-024 ARB -> DRAIN when inv_req_i is high; both readies SHALL deassert from the next cycle.
REQ-025 DRAIN SHALL issue the remaining FIFO and holding entries using the normal arbitration, then move to INV once both are empty.
REQ-026 DRAIN with both stores already empty SHALL go directly to INV on the next edge.
REQ-027 INV SHALL assert btb_inv_we_o for 256 consecutive cycles with btb_inv_idx_o = 0,1,...,255, and move to DONE after index 255; the 8-bit counter wraps to 0.
REQ-028 DONE SHALL pulse inv_done_o for one cycle, then return to ARB.
REQ-029 inv_busy_o SHALL be high in DRAIN, INV and DONE.
REQ-030 inv_req_i SHALL be ignored outside ARB.
REQ-031 When inv_req_i and a valid request coincide in ARB, that request SHALL be accepted (ready was high) and issued during DRAIN.

Reset
REQ-032 While reset is high at a rising edge: state = ARB; FIFO and holding register empty; starve_cnt = 0; invalidate index = 0.
REQ-033 After that reset edge all we outputs, inv_busy_o and inv_done_o SHALL be 0, and all payload outputs 0.
REQ-034 Reset mid-walk SHALL abort the walk with no inv_done_o; the next invalidate SHALL restart from index 0.

Verification
REQ-035 Single sp request at edge 0 (pc=0x1000, tar=0x2000) -> btb_sp_we_o=1 in the cycle after edge 1 with brpc=0x1000 and brtar=0x2000; FIFO then empty.
REQ-036 Simultaneous sp and rt each cycle for 10 cycles -> the sp path issues after every 4 rt wins; we outputs never overlap; sp_ready_o low when the FIFO is full.
REQ-037 Two sp requests with the same pc 0x40, tar 0x80 then 0xC0 -> one btb_sp_we_o issue with brtar=0xC0.
REQ-038 inv_req_i with 2 FIFO entries and 1 holding entry -> 3 issues, then 256 btb_inv_we_o cycles with index 0..255, then a 1-cycle inv_done_o; inv_busy_o spans the whole sequence.
REQ-039 Reset asserted at index 100 -> all outputs 0; a fresh inv_req_i produces a walk starting at index 0.
REQ-040 inv_req_i during INV -> ignored; exactly one inv_done_o.
